usart_tx_arbiter: RTL and testbench
===================================

# usart_tx_arbiter

Round-robin arbiter and sequencer that shares the single USART transmitter among several byte producers, such as motor telemetry, fault reporting and command echo. It accepts one byte per grant, drives `Data_Tx` and a one-cycle start strobe into the USART, and tracks the transmitter's busy flag to completion. It also reports a watchdog error if the transmitter never acknowledges a start. It sits between the BLDC control/status logic and the USART core, on the USART's `CLK`.

## Interface
- `N_REQ`, default 4: number of requesters; must be at least 2.
- `DATA_W`, default 8: byte width; must match the USART data width.
- `START_TO`, default 16: cycles allowed in WAIT_BUSY for `tx_busy` to rise; must be at least 2.
- `CLK`  in  1: single clock; all logic is on the rising edge.
- `CLR`  in  1: synchronous, active-high reset.
- `req_valid`  in  N_REQ: requester i has a byte pending.
- `req_data`  in  N_REQ*DATA_W: byte of requester i is at bits [i*DATA_W +: DATA_W].
- `req_lock`  in  N_REQ: requester i asks to keep its grant after the current byte. Only used with `USART_ARB_LOCK_EN`.
- `req_ready`  out  N_REQ: one-cycle one-hot pulse; the byte of requester i has been accepted.
- `req_done`  out  N_REQ: one-cycle one-hot pulse; the byte of requester i has finished transmitting.
- `grant`  out  N_REQ: one-hot current owner; zero in IDLE.
- `Data_Tx`  out  DATA_W: byte to the USART; held stable from START until the return to IDLE.
- `tx_start`  out  1: one-cycle start strobe to the USART.
- `tx_busy`  in  1: USART transmitter busy flag.
- `err_timeout`  out  1: one-cycle pulse when `tx_busy` fails to rise in time.

## Operation
- The FSM has four states: IDLE, START, WAIT_BUSY and WAIT_DONE.
- IDLE:
  - Arbitration happens only when `tx_busy`=0 and at least one `req_valid` bit is set.
  - The winner is the first set bit searching upward from `last`+1, modulo N_REQ.
  - The winner's `req_data` is registered into `Data_Tx`, `grant` is set to the winner, and the FSM goes to START.
- START (exactly one cycle):
  - `tx_start`=1 and `req_ready[winner]`=1.
  - The timeout counter is cleared, and the FSM goes to WAIT_BUSY.
- WAIT_BUSY:
  - If `tx_busy`=1, go to WAIT_DONE.
  - Otherwise increment the counter. When the counter reaches START_TO-1 with `tx_busy` still 0:
    - pulse `err_timeout`;
    - set `last` to the winner;
    - clear `grant`, issue no `req_done`, and go to IDLE.
- WAIT_DONE:
  - On `tx_busy`=0, pulse `req_done[winner]`, set `last` to the winner, clear `grant`, and go to IDLE.
- Requester contract:
  - `req_valid` and `req_data` must be held stable until `req_ready`.
  - Deasserting `req_valid` before it is granted simply withdraws the request.
  - `req_valid` held high after `req_ready` is treated as a new byte.
- Simultaneous requests are ordered strictly by rotation; no requester waits more than N_REQ-1 other bytes.
- The counter width is clog2(START_TO). The counter saturates and never wraps.

## Timing
- Reset values: state IDLE, `last`=N_REQ-1 (so requester 0 has first priority), counter 0, and every output 0.
- `CLR` asserted mid-transfer aborts immediately. No `req_done` or `err_timeout` is issued, and `Data_Tx` is cleared. The USART core is reset by its own `CLR`.
- Request sampled at edge k in IDLE: `tx_start` and `req_ready` are high in cycle k+1, and `Data_Tx` is valid from k+1.
- `req_done` is high in the cycle after `tx_busy` is sampled low in WAIT_DONE; the FSM is back in IDLE in that same cycle.
- Minimum spacing between `tx_start` strobes is the USART busy period plus 3 cycles.
- When `tx_busy`=1 while the FSM is in IDLE (a foreign or residual transfer), no grant is issued until `tx_busy` falls.

## Configuration
- `USART_ARB_LOCK_EN` defined:
  - In WAIT_DONE completion, if `req_lock[winner]`=1 and `req_valid[winner]`=1, the FSM goes directly to START with the same winner, loading the new `req_data` and keeping `grant` high.
  - `last` is not updated until the lock ends. This provides packet-atomic transmission.
- `USART_ARB_LOCK_EN` undefined: `req_lock` is ignored (input kept, unused) and arbitration rotates on every byte.

## Test plan
- **Single request:** after reset, req_valid=4'b0001 with byte 8'h09, and the USART model raises busy 2 cycles after start and drops it after 100 cycles → exactly one `tx_start`; `Data_Tx`=8'h09; `req_ready[0]` in the cycle after the request; `req_done[0]` once; `grant` returns to 0.
- **Rotation:** all four requesters valid continuously with bytes 8'hA0–8'hA3 → `tx_start` order is 0,1,2,3,0, and no `req_ready` overlaps another.
- **Timeout:** `tx_busy` is tied to 0 and requester 2 sends 8'h55 → `err_timeout` pulses 16 cycles after `tx_start`; no `req_done`; the next grant goes to requester 3 if it is valid.
- **Busy in IDLE:** `tx_busy`=1 for 50 cycles while requester 1 is valid → no `tx_start` until `tx_busy` falls, then `tx_start` within 2 cycles.
- **Reset mid-transfer:** `CLR` pulsed for 1 cycle during WAIT_DONE → all outputs are 0 in the next cycle, no `req_done`, and the next arbitration starts from requester 0.
- **Lock (`USART_ARB_LOCK_EN` only):** requester 1 locked with 3 bytes while requester 0 is also valid → requester 1's 3 bytes go out back-to-back, then requester 0.

Source files
------------

// File: rtl/usart_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// usart_tx_arbiter_if
// Bundle of the producer-side handshake and the USART transmitter-side
// signals used by usart_tx_arbiter.
//
// Handshake: a requester raises req_valid[i] with req_data[i*DATA_W +: DATA_W]
// and holds both until req_ready[i] pulses for one cycle (byte accepted).
// req_valid still high after that pulse offers the next byte. Dropping
// req_valid before req_ready withdraws the request. req_done[i] pulses once
// when the byte has left the transmitter; it does not pulse on a timeout.
//
// Signals:
//   req_valid   : requester i has a byte pending
//   req_data    : packed bytes, requester i at [i*DATA_W +: DATA_W]
//   req_lock    : requester i wants to keep the grant after this byte
//   req_ready   : one-hot, one-cycle byte-accepted pulse
//   req_done    : one-hot, one-cycle byte-finished pulse
//   grant       : one-hot current owner, zero when idle
//   Data_Tx     : byte presented to the USART
//   tx_start    : one-cycle start strobe to the USART
//   tx_busy     : USART transmitter busy flag
//   err_timeout : one-cycle pulse when tx_busy never rose after a start
//
// Modports:
//   slave  : the arbiter
//   master : producers plus the USART (the surrounding environment)
// ---------------------------------------------------------------------------
interface usart_tx_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
);
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_lock;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ-1:0]        req_done;
  logic [N_REQ-1:0]        grant;
  logic [DATA_W-1:0]       Data_Tx;
  logic                    tx_start;
  logic                    tx_busy;
  logic                    err_timeout;

  modport slave (
    input  req_valid, req_data, req_lock, tx_busy,
    output req_ready, req_done, grant, Data_Tx, tx_start, err_timeout
  );

  modport master (
    output req_valid, req_data, req_lock, tx_busy,
    input  req_ready, req_done, grant, Data_Tx, tx_start, err_timeout
  );
endinterface

// File: rtl/usart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// usart_tx_arbiter
// Round-robin arbiter/sequencer sharing one USART transmitter among N_REQ
// byte producers. One byte per grant: the winner's byte is registered onto
// Data_Tx, a one-cycle tx_start is issued, then tx_busy is followed to
// completion. If tx_busy never rises within START_TO cycles the transfer is
// abandoned with an err_timeout pulse.
//
// Optional feature macro: USART_ARB_LOCK_EN
//   defined   : a requester holding req_lock keeps the grant across bytes
//               (packet-atomic), rotation resumes when the lock ends.
//   undefined : req_lock is ignored, rotation advances on every byte.
//
// Ports:
//   CLK         : clock, rising edge
//   CLR         : synchronous active-high reset
//   bus         : usart_tx_arbiter_if.slave (handshake + USART signals)
//   dbg_state_o : current FSM state (0 IDLE, 1 START, 2 WAIT_BUSY, 3 WAIT_DONE)
// ---------------------------------------------------------------------------
module usart_tx_arbiter #(
  parameter int N_REQ    = 4,
  parameter int DATA_W   = 8,
  parameter int START_TO = 16
) (
  input  logic                     CLK,
  input  logic                     CLR,
  usart_tx_arbiter_if.slave        bus,
  output logic [1:0]               dbg_state_o
);

  localparam int LW = $clog2(N_REQ);
  localparam int CW = $clog2(START_TO);
  localparam logic [CW-1:0] CNT_MAX  = CW'(START_TO - 1);
  // The timeout fires on the cycle the counter would step onto START_TO-1.
  localparam logic [CW-1:0] CNT_LAST = CW'(START_TO - 2);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [LW-1:0]     last_q, last_d;
  logic [LW-1:0]     owner_q, owner_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [N_REQ-1:0]  done_q, done_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;

  // Unpacked view of the packed request bytes so they can be selected by
  // requester index.
  logic [DATA_W-1:0] req_byte [N_REQ];
  for (genvar g = 0; g < N_REQ; g++) begin : g_bytes
    assign req_byte[g] = bus.req_data[g*DATA_W +: DATA_W];
  end

  // Round-robin search: first valid requester starting at last+1, wrapping.
  logic          found;
  logic [LW-1:0] win_idx;
  logic [LW-1:0] cand;

  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = LW'((int'(last_q) + i) % N_REQ);
      if (!found && bus.req_valid[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
  end

`ifndef USART_ARB_LOCK_EN
  logic unused_lock;
  assign unused_lock = ^bus.req_lock;
`endif

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q <= IDLE;
      last_q  <= LW'(N_REQ - 1);
      owner_q <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    data_d  = data_q;
    done_d  = '0;
    err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A busy transmitter in IDLE is a foreign or residual transfer;
        // hold off until it drains.
        if (!bus.tx_busy && found) begin
          owner_d          = win_idx;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          data_d           = req_byte[win_idx];
          state_d          = START;
        end
      end

      START: begin
        cnt_d   = '0;
        state_d = WAIT_BUSY;
      end

      WAIT_BUSY: begin
        if (bus.tx_busy) begin
          state_d = WAIT_DONE;
        end else begin
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
          end
          if (cnt_q == CNT_LAST) begin
            err_d   = 1'b1;
            last_d  = owner_q;
            grant_d = '0;
            state_d = IDLE;
          end
        end
      end

      WAIT_DONE: begin
        if (!bus.tx_busy) begin
          done_d = grant_q;
`ifdef USART_ARB_LOCK_EN
          // Locked owner with another byte ready: skip arbitration and keep
          // last unchanged so rotation resumes after the packet.
          if (bus.req_lock[owner_q] && bus.req_valid[owner_q]) begin
            data_d  = req_byte[owner_q];
            state_d = START;
          end else begin
            last_d  = owner_q;
            grant_d = '0;
            state_d = IDLE;
          end
`else
          last_d  = owner_q;
          grant_d = '0;
          state_d = IDLE;
`endif
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.tx_start    = (state_q == START);
  assign bus.req_ready   = (state_q == START) ? grant_q : '0;
  assign bus.req_done    = done_q;
  assign bus.grant       = grant_q;
  assign bus.Data_Tx     = data_q;
  assign bus.err_timeout = err_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_usart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_usart_tx_arbiter
// Directed bench for usart_tx_arbiter (N_REQ=4, DATA_W=8, START_TO=16).
// A small USART model raises tx_busy two edges after a start and holds it
// for busy_len cycles; force_busy emulates a foreign transfer. Inputs are
// driven and outputs checked 1 time unit after the falling edge.
// ---------------------------------------------------------------------------
module tb_usart_tx_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 16;

  logic       CLK = 1'b0;
  logic       CLR = 1'b1;
  logic [1:0] dbg_state;

  logic model_en   = 1'b0;
  logic force_busy = 1'b0;
  logic model_busy = 1'b0;
  int   busy_len   = 100;
  int   m_rise     = 0;
  int   m_hold     = 0;

  int cyc       = 0;
  int n_cmp     = 0;
  int n_err     = 0;
  int n_start   = 0;
  int n_done    = 0;
  int n_to      = 0;
  int n_overlap = 0;
  int start_cyc = 0;
  int to_cyc    = 0;
  int lat       = 0;
  int ns        = 0;
  int nd        = 0;

  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];

  usart_tx_arbiter_if #(.N_REQ(N), .DATA_W(W)) bus ();

  usart_tx_arbiter #(.N_REQ(N), .DATA_W(W), .START_TO(TO)) dut (
    .CLK         (CLK),
    .CLR         (CLR),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  assign bus.tx_busy = model_busy | force_busy;

  // Clock / reset block
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // USART model, reset together with the arbiter
  always @(posedge CLK) begin
    if (CLR) begin
      model_busy <= 1'b0;
      m_rise     <= 0;
      m_hold     <= 0;
    end else begin
      if (m_rise != 0) begin
        m_rise <= m_rise - 1;
        if (m_rise == 1) begin
          model_busy <= 1'b1;
          m_hold     <= busy_len;
        end
      end else if (m_hold != 0) begin
        m_hold <= m_hold - 1;
        if (m_hold == 1) model_busy <= 1'b0;
      end
      if (model_en && bus.tx_start) m_rise <= 2;
    end
  end

  function automatic int oh2idx(input logic [N-1:0] v);
    int r;
    r = 255;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Monitor: records every start as {index, byte}
  always @(negedge CLK) begin
    if (bus.tx_start) begin
      n_start++;
      start_cyc = cyc;
      obs_q.push_back({8'(oh2idx(bus.req_ready)), bus.Data_Tx});
    end
    if (bus.req_done != '0) n_done++;
    if (bus.err_timeout) begin
      n_to++;
      to_cyc = cyc;
    end
    if ($countones(bus.req_ready) > 1) n_overlap++;
  end

  // Driver / checker tasks
  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_starts();
    logic [15:0] e;
    logic [15:0] o;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() != 0) o = obs_q.pop_front();
      else o = 'x;
      check("start_idx_byte", {16'h0, o}, {16'h0, e});
    end
  endtask

  task automatic wait_start(input int bound, output int l);
    int n;
    n = 0;
    while (bus.tx_start !== 1'b1 && n < bound) begin
      step();
      n++;
    end
    l = n;
    check("tx_start_seen", bus.tx_start, 1);
  endtask

  task automatic wait_done(input logic [N-1:0] exp, input int bound);
    int n;
    n = 0;
    while (bus.req_done === '0 && n < bound) begin
      step();
      n++;
    end
    check("req_done", bus.req_done, exp);
  endtask

  task automatic wait_err(input int bound);
    int n;
    n = 0;
    while (bus.err_timeout !== 1'b1 && n < bound) begin
      step();
      n++;
    end
    check("err_timeout_seen", bus.err_timeout, 1);
  endtask

  task automatic wait_state(input logic [1:0] st, input int bound);
    int n;
    n = 0;
    while (dbg_state !== st && n < bound) begin
      step();
      n++;
    end
    check("state_reach", dbg_state, st);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"},  bus.grant, 0);
    check({tag, "_start"},  bus.tx_start, 0);
    check({tag, "_ready"},  bus.req_ready, 0);
    check({tag, "_done"},   bus.req_done, 0);
    check({tag, "_data"},   bus.Data_Tx, 0);
    check({tag, "_err"},    bus.err_timeout, 0);
    check({tag, "_state"},  dbg_state, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation ran past its time limit");
    $fatal(1, "time limit");
  end

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_lock  = '0;

    // Reset state
    CLR = 1'b1;
    repeat (3) step();
    CLR = 1'b0;
    check_all_zero("rst");

    // Single request: byte 09 from requester 0
    model_en = 1'b1;
    busy_len = 100;
    bus.req_data[7:0] = 8'h09;
    bus.req_valid     = 4'b0001;
    step();
    check("t1_tx_start", bus.tx_start, 1);
    check("t1_ready",    bus.req_ready, 4'b0001);
    check("t1_data",     bus.Data_Tx, 8'h09);
    check("t1_grant",    bus.grant, 4'b0001);
    exp_q.push_back({8'd0, 8'h09});
    bus.req_valid = '0;
    wait_done(4'b0001, 300);
    check("t1_idle_at_done", dbg_state, 0);
    check("t1_grant_clear",  bus.grant, 0);
    check("t1_data_held",    bus.Data_Tx, 8'h09);
    step();
    check("t1_done_one_cycle", bus.req_done, 0);
    check("t1_start_count",    n_start, 1);
    check("t1_done_count",     n_done, 1);
    check_starts();

    // Rotation from a fresh reset: 0,1,2,3,0
    CLR = 1'b1;
    step();
    CLR = 1'b0;
    busy_len = 5;
    bus.req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    bus.req_valid = 4'b1111;
    ns = n_start;
    for (int i = 0; i < 400 && n_start < ns + 5; i++) step();
    bus.req_valid = '0;
    check("t2_start_count", n_start - ns, 5);
    exp_q.push_back({8'd0, 8'hA0});
    exp_q.push_back({8'd1, 8'hA1});
    exp_q.push_back({8'd2, 8'hA2});
    exp_q.push_back({8'd3, 8'hA3});
    exp_q.push_back({8'd0, 8'hA0});
    wait_state(2'd0, 100);
    check("t2_no_overlap", n_overlap, 0);
    check_starts();

    // Timeout: transmitter never goes busy
    model_en = 1'b0;
    step();
    bus.req_data  = {8'h33, 8'h55, 8'h00, 8'h00};
    bus.req_valid = 4'b1100;
    wait_start(10, lat);
    exp_q.push_back({8'd2, 8'h55});
    check("t3_grant", bus.grant, 4'b0100);
    bus.req_valid = 4'b1000;
    nd = n_done;
    wait_err(50);
    check("t3_err_delay", to_cyc - start_cyc, TO);
    check("t3_grant_clear", bus.grant, 0);
    check("t3_idle", dbg_state, 0);
    check("t3_no_done_pulse", bus.req_done, 0);
    wait_start(10, lat);
    check("t3_regrant_lat", lat, 1);
    exp_q.push_back({8'd3, 8'h33});
    bus.req_valid = '0;
    wait_err(50);
    check("t3_no_done", n_done, nd);
    check("t3_err_count", n_to, 2);
    check_starts();

    // Busy in IDLE: hold off until tx_busy falls
    model_en   = 1'b1;
    busy_len   = 5;
    force_busy = 1'b1;
    bus.req_data[15:8] = 8'h11;
    bus.req_valid      = 4'b0010;
    ns = n_start;
    repeat (50) step();
    check("t4_no_start_while_busy", n_start, ns);
    force_busy = 1'b0;
    wait_start(10, lat);
    check("t4_start_lat", lat, 1);
    exp_q.push_back({8'd1, 8'h11});
    bus.req_valid = '0;
    wait_done(4'b0010, 100);
    check_starts();

    // Reset mid-transfer (WAIT_DONE)
    busy_len = 100;
    step();
    bus.req_data[23:16] = 8'h77;
    bus.req_valid       = 4'b0100;
    wait_start(10, lat);
    exp_q.push_back({8'd2, 8'h77});
    bus.req_valid = '0;
    wait_state(2'd3, 20);
    nd  = n_done;
    CLR = 1'b1;
    step();
    check_all_zero("t5");
    CLR = 1'b0;
    bus.req_data[7:0] = 8'h5A;
    bus.req_valid     = 4'b0101;
    wait_start(10, lat);
    check("t5_restart_lat", lat, 1);
    check("t5_no_done_after_clr", n_done, nd);
    exp_q.push_back({8'd0, 8'h5A});
    bus.req_valid = '0;
    wait_done(4'b0001, 300);
    check_starts();

`ifdef USART_ARB_LOCK_EN
    // Lock: requester 1 sends three bytes back-to-back, then requester 0
    busy_len = 5;
    step();
    bus.req_data[7:0]  = 8'hC0;
    bus.req_data[15:8] = 8'hB1;
    bus.req_lock       = 4'b0010;
    bus.req_valid      = 4'b0011;
    for (int b = 0; b < 3; b++) begin
      wait_start(100, lat);
      if (b == 0) bus.req_data[15:8] = 8'hB2;
      if (b == 1) bus.req_data[15:8] = 8'hB3;
      if (b == 2) begin
        bus.req_valid[1] = 1'b0;
        bus.req_lock     = '0;
      end
      if (b < 2) step();
    end
    exp_q.push_back({8'd1, 8'hB1});
    exp_q.push_back({8'd1, 8'hB2});
    exp_q.push_back({8'd1, 8'hB3});
    step();
    wait_start(100, lat);
    exp_q.push_back({8'd0, 8'hC0});
    bus.req_valid = '0;
    wait_state(2'd0, 100);
    check_starts();
`endif

    check("final_no_overlap", n_overlap, 0);
    check("final_grant", bus.grant, 0);
    check("final_no_extra_starts", obs_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
